// File: rtl/exu_pkg.sv
// Shared encodings for the execute / load-store stage: ALU op codes,
// operand-B select, branch codes, memory-op codes, FSM states and the
// small decode helpers used by both the issue and the load paths.
package exu_pkg;

    // ALU operation, aluctr[2:0]; aluctr[3] selects the variant
    localparam logic [2:0] ALU_ADD   = 3'b000;  // add / sub
    localparam logic [2:0] ALU_SLL   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;  // signed / unsigned
    localparam logic [2:0] ALU_PASSB = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SR    = 3'b101;  // srl / sra
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_AND   = 3'b111;

    // Operand-B source
    localparam logic [1:0] BSRC_SRC2  = 2'b00;
    localparam logic [1:0] BSRC_IMM   = 2'b01;
    localparam logic [1:0] BSRC_FOUR  = 2'b10;
    localparam logic [1:0] BSRC_ZERO  = 2'b11;

    // Branch / jump kind
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_EQ   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LT   = 3'b110;
    localparam logic [2:0] BR_GE   = 3'b111;

    // Memory operation
    localparam logic [2:0] MEM_B    = 3'b000;
    localparam logic [2:0] MEM_H    = 3'b001;
    localparam logic [2:0] MEM_W    = 3'b010;
    localparam logic [2:0] MEM_D    = 3'b011;
    localparam logic [2:0] MEM_BU   = 3'b100;
    localparam logic [2:0] MEM_HU   = 3'b101;
    localparam logic [2:0] MEM_WU   = 3'b110;
    localparam logic [2:0] MEM_NONE = 3'b111;

    // Access size as log2(bytes)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Access size of a memop; a dword request on a 32-bit datapath is
    // treated as a word so lane masks never exceed the bus.
    function automatic logic [1:0] mem_size(input logic [2:0] memop, input int xlen);
        logic [1:0] sz;
        case (memop)
            MEM_B, MEM_BU: sz = SZ_B;
            MEM_H, MEM_HU: sz = SZ_H;
            MEM_W, MEM_WU: sz = SZ_W;
            MEM_D:         sz = SZ_D;
            default:       sz = SZ_B;
        endcase
        if (xlen == 32 && sz == SZ_D) begin
            sz = SZ_W;
        end
        return sz;
    endfunction

    function automatic logic mem_unsigned(input logic [2:0] memop);
        return (memop == MEM_BU) || (memop == MEM_HU) || (memop == MEM_WU);
    endfunction

    // One bit per byte lane covered by an access of the given size,
    // starting at lane 0.
    function automatic logic [7:0] lane_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/exu_alu.sv
// Combinational integer ALU. The operation comes from aluctr[2:0];
// aluctr[3] picks sub, unsigned compare or arithmetic right shift.
module exu_alu
    import exu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [3:0]      aluctr,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;

    assign shamt = b[SHAMT_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Operation select; sra is its own statement so the signed shift is
    // not turned unsigned by a surrounding conditional expression.
    always_comb begin
        result = '0;
        case (aluctr[2:0])
            ALU_ADD: begin
                if (aluctr[3]) begin
                    result = a - b;
                end else begin
                    result = a + b;
                end
            end
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, (aluctr[3] ? lt_u : lt_s)};
            ALU_PASSB: result = b;
            ALU_XOR:   result = a ^ b;
            ALU_SR: begin
                if (aluctr[3]) begin
                    result = $signed(a) >>> shamt;
                end else begin
                    result = a >> shamt;
                end
            end
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/exu_lsu.sv
// Execute + load/store stage. An issued op is evaluated by the ALU in
// the accepting cycle; ALU-only and misaligned ops go straight to DONE,
// memory ops run one request/response exchange before write-back.
module exu_lsu
    import exu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst,
    // issue from decode
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     imm,
    input  logic [3:0]          aluctr,
    input  logic                aluasrc,
    input  logic [1:0]          alubsrc,
    input  logic [2:0]          branch,
    input  logic [2:0]          memop,
    input  logic                memwr,
    input  logic                memtoreg,
    // write-back
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     wd,
    output logic                pc_a_src,
    output logic                pc_b_src,
    output logic                misalign,
    // memory request / response
    output logic                req_valid,
    input  logic                req_ready,
    output logic                req_wr,
    output logic [XLEN-1:0]     req_addr,
    output logic [XLEN-1:0]     req_wdata,
    output logic [XLEN/8-1:0]   req_wstrb,
    input  logic                resp_valid,
    input  logic [XLEN-1:0]     resp_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_t state_reg, state_next;

    logic [XLEN-1:0] op_a, op_b, alu_res;

    logic [2:0]      memop_reg;
    logic            memwr_reg;
    logic            memtoreg_reg;
    logic [XLEN-1:0] wd_reg;
    logic            misalign_reg;
    logic            pc_a_src_reg, pc_b_src_reg;
    logic            req_wr_reg;
    logic [XLEN-1:0] req_addr_reg, req_wdata_reg;
    logic [NB-1:0]   req_wstrb_reg;

    // Operand selection feeding the ALU
    always_comb begin
        op_a = aluasrc ? pc : src1;
        case (alubsrc)
            BSRC_SRC2: op_b = src2;
            BSRC_IMM:  op_b = imm;
            BSRC_FOUR: op_b = XLEN'(4);
            BSRC_ZERO: op_b = '0;
            default:   op_b = '0;
        endcase
    end

    exu_alu #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .aluctr (aluctr),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res)
    );

    // ---------------- issue-side memory decode ----------------
    logic             is_mem, mis_in;
    logic [1:0]       size_in;
    logic [7:0]       lanes_in;
    logic [OFF_W-1:0] off_in;
    logic [NB-1:0]    strb_in;
    logic [XLEN-1:0]  wdata_in;

    assign is_mem   = (memop != MEM_NONE);
    assign size_in  = mem_size(memop, XLEN);
    assign lanes_in = lane_mask(size_in);
    assign off_in   = alu_res[OFF_W-1:0];
    // lanes>>1 equals (bytes-1): the address bits that must be zero
    assign mis_in   = is_mem && (|(off_in & lanes_in[OFF_W:1]));
    assign strb_in  = lanes_in[NB-1:0] << off_in;

    // Store data replicated across every lane so the strobe alone picks
    // the bytes that land in memory.
    always_comb begin
        case (size_in)
            SZ_B:    wdata_in = {NB{src2[7:0]}};
            SZ_H:    wdata_in = {(NB/2){src2[15:0]}};
            SZ_W:    wdata_in = {(NB/4){src2[31:0]}};
            default: wdata_in = src2;
        endcase
    end

    // ---------------- load data alignment ----------------
    logic [1:0]       size_ld;
    logic [7:0]       lanes_ld;
    logic [OFF_W-1:0] off_ld;
    logic [XLEN-1:0]  rd_shift, keep_mask, load_data;
    logic             sign_bit;

    assign size_ld  = mem_size(memop_reg, XLEN);
    assign lanes_ld = lane_mask(size_ld);
    assign off_ld   = req_addr_reg[OFF_W-1:0];
    assign rd_shift = resp_rdata >> {off_ld, 3'b000};

    // Each result bit is kept if its byte lane belongs to the access
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_keep
        assign keep_mask[gi] = lanes_ld[gi / 8];
    end

    // Sign bit of the addressed field, forced low for unsigned loads
    always_comb begin
        case (size_ld)
            SZ_B:    sign_bit = rd_shift[7];
            SZ_H:    sign_bit = rd_shift[15];
            SZ_W:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[XLEN-1];
        endcase
        if (mem_unsigned(memop_reg)) begin
            sign_bit = 1'b0;
        end
    end

    assign load_data = (rd_shift & keep_mask) | ({XLEN{sign_bit}} & ~keep_mask);

    // ---------------- branch decode ----------------
    logic br_a, br_b, alu_zero;
    assign alu_zero = (alu_res == '0);

    // Branch outcome from the ALU result of the op being accepted
    always_comb begin
        br_a = 1'b0;
        br_b = 1'b0;
        case (branch)
            BR_NONE: ;
            BR_JAL:  br_a = 1'b1;
            BR_JALR: begin
                br_a = 1'b1;
                br_b = 1'b1;
            end
            BR_EQ:   br_a = alu_zero;
            BR_NE:   br_a = ~alu_zero;
            BR_LT:   br_a = alu_res[0];
            BR_GE:   br_a = ~alu_res[0];
            default: ;
        endcase
    end

    // ---------------- control ----------------
    // Next-state logic of the issue / request / wait / write-back FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = (!is_mem || mis_in) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_next = (memwr_reg && resp_valid) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp_valid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; results are latched at acceptance
    // and only the load data is filled in later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            memop_reg     <= MEM_NONE;
            memwr_reg     <= 1'b0;
            memtoreg_reg  <= 1'b0;
            wd_reg        <= '0;
            misalign_reg  <= 1'b0;
            pc_a_src_reg  <= 1'b0;
            pc_b_src_reg  <= 1'b0;
            req_wr_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            req_wstrb_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        memop_reg    <= memop;
                        memwr_reg    <= memwr;
                        memtoreg_reg <= memtoreg;
                        misalign_reg <= mis_in;
                        pc_a_src_reg <= br_a;
                        pc_b_src_reg <= br_b;
                        wd_reg       <= (mis_in || memtoreg) ? '0 : alu_res;
                        if (is_mem && !mis_in) begin
                            req_addr_reg  <= alu_res;
                            req_wr_reg    <= memwr;
                            req_wdata_reg <= memwr ? wdata_in : '0;
                            req_wstrb_reg <= memwr ? strb_in : '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (resp_valid && !memwr_reg && memtoreg_reg) begin
                        wd_reg <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign req_valid = (state_reg == ST_REQ);
    assign wd        = wd_reg;
    assign misalign  = misalign_reg;
    assign pc_a_src  = pc_a_src_reg;
    assign pc_b_src  = pc_b_src_reg;
    assign req_wr    = req_wr_reg;
    assign req_addr  = req_addr_reg;
    assign req_wdata = req_wdata_reg;
    assign req_wstrb = req_wstrb_reg;

endmodule

// File: tb/tb_exu_lsu.sv
// Bench for exu_lsu (XLEN=32): a vector table of ALU/branch ops plus
// hand-written load/store, misalign and reset sequences. Expected
// write-back results go through a scoreboard queue.
module tb_exu_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] src1, src2, pc, imm;
    logic [3:0]  aluctr;
    logic        aluasrc;
    logic [1:0]  alubsrc;
    logic [2:0]  branch, memop;
    logic        memwr, memtoreg;
    logic        out_valid, out_ready;
    logic [31:0] wd;
    logic        pc_a_src, pc_b_src, misalign;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    exu_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .src1       (src1),
        .src2       (src2),
        .pc         (pc),
        .imm        (imm),
        .aluctr     (aluctr),
        .aluasrc    (aluasrc),
        .alubsrc    (alubsrc),
        .branch     (branch),
        .memop      (memop),
        .memwr      (memwr),
        .memtoreg   (memtoreg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wd         (wd),
        .pc_a_src   (pc_a_src),
        .pc_b_src   (pc_b_src),
        .misalign   (misalign),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src1, src2, pc, imm;
        logic [3:0]  aluctr;
        logic        aluasrc;
        logic [1:0]  alubsrc;
        logic [2:0]  branch;
        logic [31:0] wd;
        logic        pa, pb;
    } vec_t;

    typedef struct packed {
        logic [31:0] wd;
        logic        pa, pb, mis;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[18];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] p, input logic [31:0] im,
                                input logic [3:0] ac, input logic as, input logic [1:0] bs,
                                input logic [2:0] br, input logic [31:0] ewd,
                                input logic epa, input logic epb);
        vec_t v;
        v.src1 = s1; v.src2 = s2; v.pc = p; v.imm = im;
        v.aluctr = ac; v.aluasrc = as; v.alubsrc = bs; v.branch = br;
        v.wd = ewd; v.pa = epa; v.pb = epb;
        return v;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; src1 = '0; src2 = '0; pc = '0; imm = '0;
        aluctr = '0; aluasrc = 1'b0; alubsrc = 2'b00; branch = 3'b000;
        memop = 3'b111; memwr = 1'b0; memtoreg = 1'b0;
    endtask

    // Wait (bounded) for out_valid, compare against the scoreboard head,
    // then complete the write-back handshake.
    task automatic collect(input string name);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout: out_valid never rose", name);
            return;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb: output with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            check({name, "_wd"},  64'(wd),       64'(e.wd));
            check({name, "_pa"},  64'(pc_a_src), 64'(e.pa));
            check({name, "_pb"},  64'(pc_b_src), 64'(e.pb));
            check({name, "_mis"}, 64'(misalign), 64'(e.mis));
        end
        $display("txn %s wd=%08h pa=%0d pb=%0d mis=%0d", name, wd, pc_a_src, pc_b_src, misalign);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1; src1 = v.src1; src2 = v.src2; pc = v.pc; imm = v.imm;
        aluctr = v.aluctr; aluasrc = v.aluasrc; alubsrc = v.alubsrc; branch = v.branch;
        memop = 3'b111; memwr = 1'b0; memtoreg = 1'b0;
        e.wd = v.wd; e.pa = v.pa; e.pb = v.pb; e.mis = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        idle_inputs();
        check({name, "_latency"}, 64'(out_valid), 64'(1));
        collect(name);
    endtask

    // Memory op with address src1+imm; stall = cycles req_ready is held low.
    task automatic mem_txn(input string name, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] sdata, input logic [2:0] mop, input logic wr,
                           input logic [31:0] rdata, input int stall, input logic same_resp,
                           input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_wd);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; src1 = base; imm = off; src2 = sdata;
        aluctr = 4'b0000; aluasrc = 1'b0; alubsrc = 2'b01; branch = 3'b000;
        memop = mop; memwr = wr; memtoreg = ~wr;
        e.wd = exp_wd; e.pa = 1'b0; e.pb = 1'b0; e.mis = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        idle_inputs();
        check({name, "_req_valid"}, 64'(req_valid), 64'(1));
        check({name, "_req_addr"},  64'(req_addr),  64'(exp_addr));
        check({name, "_req_wr"},    64'(req_wr),    64'(wr));
        check({name, "_req_wstrb"}, 64'(req_wstrb), 64'(exp_strb));
        check({name, "_req_wdata"}, 64'(req_wdata), 64'(exp_wdata));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, "_stall_valid"}, 64'(req_valid), 64'(1));
            check({name, "_stall_addr"},  64'(req_addr),  64'(exp_addr));
        end
        req_ready = 1'b1;
        resp_valid = same_resp;
        @(negedge clk);
        req_ready = 1'b0;
        resp_valid = 1'b0;
        if (!same_resp) begin
            resp_valid = 1'b1;
            resp_rdata = rdata;
            @(negedge clk);
            resp_valid = 1'b0;
            resp_rdata = '0;
        end
        collect(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"},  64'(in_ready),  64'(1));
        check({name, "_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_req_valid"}, 64'(req_valid), 64'(0));
        check({name, "_req_wr"},    64'(req_wr),    64'(0));
        check({name, "_req_addr"},  64'(req_addr),  64'(0));
        check({name, "_req_wdata"}, 64'(req_wdata), 64'(0));
        check({name, "_req_wstrb"}, 64'(req_wstrb), 64'(0));
        check({name, "_wd"},        64'(wd),        64'(0));
        check({name, "_misalign"},  64'(misalign),  64'(0));
        check({name, "_pa"},        64'(pc_a_src),  64'(0));
        check({name, "_pb"},        64'(pc_b_src),  64'(0));
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mk(32'd5,        32'd0,    32'h0,   32'd7, 4'b0000, 1'b0, 2'b01, 3'b000, 32'd12,       1'b0, 1'b0);
        vecs[1]  = mk(32'd10,       32'd3,    32'h0,   32'd0, 4'b1000, 1'b0, 2'b00, 3'b000, 32'd7,        1'b0, 1'b0);
        vecs[2]  = mk(32'd1,        32'd33,   32'h0,   32'd0, 4'b0001, 1'b0, 2'b00, 3'b000, 32'd2,        1'b0, 1'b0);
        vecs[3]  = mk(32'hFFFFFFFF, 32'd1,    32'h0,   32'd0, 4'b0010, 1'b0, 2'b00, 3'b000, 32'd1,        1'b0, 1'b0);
        vecs[4]  = mk(32'hFFFFFFFF, 32'd1,    32'h0,   32'd0, 4'b1010, 1'b0, 2'b00, 3'b000, 32'd0,        1'b0, 1'b0);
        vecs[5]  = mk(32'd0,        32'd0,    32'h0,   32'd0, 4'b0011, 1'b0, 2'b10, 3'b000, 32'd4,        1'b0, 1'b0);
        vecs[6]  = mk(32'hF0F0,     32'h0FF0, 32'h0,   32'd0, 4'b0100, 1'b0, 2'b00, 3'b000, 32'hFF00,     1'b0, 1'b0);
        vecs[7]  = mk(32'h80000000, 32'd4,    32'h0,   32'd0, 4'b0101, 1'b0, 2'b00, 3'b000, 32'h08000000, 1'b0, 1'b0);
        vecs[8]  = mk(32'h80000000, 32'd4,    32'h0,   32'd0, 4'b1101, 1'b0, 2'b00, 3'b000, 32'hF8000000, 1'b0, 1'b0);
        vecs[9]  = mk(32'hF0,       32'h0F,   32'h0,   32'd0, 4'b0110, 1'b0, 2'b00, 3'b000, 32'hFF,       1'b0, 1'b0);
        vecs[10] = mk(32'hFF,       32'h3C,   32'h0,   32'd0, 4'b0111, 1'b0, 2'b00, 3'b000, 32'h3C,       1'b0, 1'b0);
        vecs[11] = mk(32'd0,        32'd0,    32'h100, 32'd0, 4'b0000, 1'b1, 2'b10, 3'b001, 32'h104,      1'b1, 1'b0);
        vecs[12] = mk(32'd0,        32'd0,    32'h200, 32'd0, 4'b0000, 1'b1, 2'b10, 3'b010, 32'h204,      1'b1, 1'b1);
        vecs[13] = mk(32'd3,        32'd3,    32'h0,   32'd0, 4'b1000, 1'b0, 2'b00, 3'b100, 32'd0,        1'b1, 1'b0);
        vecs[14] = mk(32'd3,        32'd3,    32'h0,   32'd0, 4'b1000, 1'b0, 2'b00, 3'b101, 32'd0,        1'b0, 1'b0);
        vecs[15] = mk(32'hFFFFFFFB, 32'd2,    32'h0,   32'd0, 4'b0010, 1'b0, 2'b00, 3'b110, 32'd1,        1'b1, 1'b0);
        vecs[16] = mk(32'hFFFFFFFB, 32'd2,    32'h0,   32'd0, 4'b0010, 1'b0, 2'b00, 3'b111, 32'd1,        1'b0, 1'b0);
        vecs[17] = mk(32'd9,        32'd55,   32'h0,   32'd0, 4'b0000, 1'b0, 2'b11, 3'b000, 32'd9,        1'b0, 1'b0);

        idle_inputs();
        out_ready = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("alu%0d", i), vecs[i]);
        end

        // name base off sdata memop wr rdata stall same addr strb wdata wd
        mem_txn("lb",  32'h1000, 32'd3, 32'h0,    3'b000, 1'b0, 32'h80FFFFFF, 0, 1'b0, 32'h1003, 4'b0000, 32'h0,        32'hFFFFFF80);
        mem_txn("lbu", 32'h1000, 32'd3, 32'h0,    3'b100, 1'b0, 32'h80FFFFFF, 0, 1'b0, 32'h1003, 4'b0000, 32'h0,        32'h00000080);
        mem_txn("lh",  32'h1000, 32'd2, 32'h0,    3'b001, 1'b0, 32'h80FF1234, 1, 1'b0, 32'h1002, 4'b0000, 32'h0,        32'hFFFF80FF);
        mem_txn("lhu", 32'h1000, 32'd2, 32'h0,    3'b101, 1'b0, 32'h80FF1234, 0, 1'b0, 32'h1002, 4'b0000, 32'h0,        32'h000080FF);
        mem_txn("lw",  32'h1000, 32'd4, 32'h0,    3'b010, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h1004, 4'b0000, 32'h0,        32'hDEADBEEF);
        mem_txn("sh",  32'h2000, 32'd2, 32'hABCD, 3'b001, 1'b1, 32'h0,        0, 1'b1, 32'h2002, 4'b1100, 32'hABCDABCD, 32'h2002);
        mem_txn("sb",  32'h2000, 32'd1, 32'h5A,   3'b000, 1'b1, 32'h0,        3, 1'b0, 32'h2001, 4'b0010, 32'h5A5A5A5A, 32'h2001);
        mem_txn("sw",  32'h2000, 32'd8, 32'h12345678, 3'b010, 1'b1, 32'h0,    0, 1'b0, 32'h2008, 4'b1111, 32'h12345678, 32'h2008);

        // misaligned word load: no request, zero write-back, next-cycle out_valid
        @(negedge clk);
        in_valid = 1'b1; src1 = 32'h2000; imm = 32'd1; alubsrc = 2'b01;
        memop = 3'b010; memwr = 1'b0; memtoreg = 1'b1;
        e.wd = 32'h0; e.pa = 1'b0; e.pb = 1'b0; e.mis = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        idle_inputs();
        check("mis_req_valid", 64'(req_valid), 64'(0));
        check("mis_latency",   64'(out_valid), 64'(1));
        collect("lw_mis");

        // stalled load abandoned by reset in WAIT, then a stray response
        @(negedge clk);
        in_valid = 1'b1; src1 = 32'h3000; imm = 32'd0; alubsrc = 2'b01;
        memop = 3'b010; memwr = 1'b0; memtoreg = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("rstw_req_valid", 64'(req_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw_stall_addr", 64'(req_addr), 64'(32'h3000));
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("rstw_in_wait", 64'({req_valid, out_valid, in_ready}), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rstw");
        resp_valid = 1'b1; resp_rdata = 32'hCAFEF00D;
        @(negedge clk);
        resp_valid = 1'b0; resp_rdata = '0;
        check("stray_out_valid", 64'(out_valid), 64'(0));
        check("stray_in_ready",  64'(in_ready),  64'(1));
        check("stray_wd",        64'(wd),        64'(0));
        @(negedge clk);
        check("stray_out_valid2", 64'(out_valid), 64'(0));

        run_vec("post_rst", vecs[0]);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
